// File: rtl/rx_ctrl.sv
// Receive controller: syncs receiver busy, captures each frame's byte at frame end, queues good bytes.
// Latency: byte visible on out_data 3 sys_clk edges after rx_busy is first sampled low; zero read latency at head.
// Backpressure: out_valid/out_ready handshake; a good byte arriving when full (with no same-cycle pop) is dropped and flags overrun.
//
// Ports:
//   sys_clk, rst_n      - clock, async active-low reset
//   enable              - 1 = accept frames, 0 = idle (FIFO keeps its contents and can still be drained)
//   rx_busy             - receiver busy flag (asynchronous, double-flopped here)
//   rx_data, rx_parity_ok - receiver byte and parity result, stable while rx_busy = 0
//   out_data, out_valid, out_ready - FIFO head and handshake
//   fifo_count          - FIFO occupancy
//   overrun, parity_err_cnt, clear_stats - sticky overrun, saturating bad-parity count, clear pulse
module rx_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     rx_busy,
    input  logic [7:0]               rx_data,
    input  logic                     rx_parity_ok,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    output logic [7:0]               parity_err_cnt,
    input  logic                     clear_stats
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_IDLE    = 2'd1,
        S_RECV    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t          state;
    logic            busy_meta;
    logic            busy_s;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            capture;
    logic            cap_good;
    logic            cap_bad;
    logic            full;
    logic            pop;
    logic            push;
    logic            ovr_set;

    // The receiver runs off its own clock, so busy is only trusted after two flops.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= rx_busy;
            busy_s    <= busy_meta;
        end
    end

    // Control FSM. Waiting in OFF for busy_s = 0 skips a frame already in flight
    // when enable rises, so we never capture a partial frame.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OFF;
        end else if (!enable) begin
            state <= S_OFF;
        end else begin
            unique case (state)
                S_OFF:     if (!busy_s) state <= S_IDLE;
                S_IDLE:    if (busy_s)  state <= S_RECV;
                S_RECV:    if (!busy_s) state <= S_CAPTURE;
                S_CAPTURE: state <= S_IDLE;
                default:   state <= S_OFF;
            endcase
        end
    end

    // The CAPTURE cycle is when rx_data/rx_parity_ok are consumed.
    assign capture  = (state == S_CAPTURE);
    assign cap_good = capture &  rx_parity_ok;
    assign cap_bad  = capture & ~rx_parity_ok;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count == CW'(DEPTH));
    // A pop in the same cycle frees the head slot, so a full FIFO can still take the byte.
    assign push      = cap_good & (~full | pop);
    assign ovr_set   = cap_good & full & ~pop;

    // Stale memory is masked so the head reads zero whenever the FIFO is empty.
    assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // clear_stats wins over a same-cycle increment or overrun; that event is discarded.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun        <= 1'b0;
            parity_err_cnt <= 8'h00;
        end else if (clear_stats) begin
            overrun        <= 1'b0;
            parity_err_cnt <= 8'h00;
        end else begin
            if (ovr_set) overrun <= 1'b1;
            if (cap_bad && parity_err_cnt != 8'hFF) parity_err_cnt <= parity_err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_ctrl.sv
// Testbench for rx_ctrl: directed scenarios plus randomized frames checked against a queue-based model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_ctrl;

    localparam int DEPTH = 4;

    logic                    sys_clk;
    logic                    rst_n;
    logic                    enable;
    logic                    rx_busy;
    logic [7:0]              rx_data;
    logic                    rx_parity_ok;
    logic [7:0]              out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    overrun;
    logic [7:0]              parity_err_cnt;
    logic                    clear_stats;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queue, sticky overrun, saturating error count.
    logic [7:0] q[$];
    bit         m_ovr = 1'b0;
    int         m_err = 0;

    rx_ctrl #(.DEPTH(DEPTH)) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .rx_busy        (rx_busy),
        .rx_data        (rx_data),
        .rx_parity_ok   (rx_parity_ok),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_count     (fifo_count),
        .overrun        (overrun),
        .parity_err_cnt (parity_err_cnt),
        .clear_stats    (clear_stats)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},   32'(out_valid),      32'(q.size() != 0));
        check({tag, ".count"},   32'(fifo_count),     32'(q.size()));
        if (q.size() != 0) check({tag, ".head"}, 32'(out_data), 32'(q[0]));
        else               check({tag, ".head0"}, 32'(out_data), 32'h0);
        check({tag, ".overrun"}, 32'(overrun),        32'(m_ovr));
        check({tag, ".errcnt"},  32'(parity_err_cnt), 32'(m_err));
    endtask

    // One complete frame while enabled; optionally pop and/or clear on the capture edge.
    task automatic frame(input logic [7:0] d, input bit ok, input bit pop_cap, input bit clr_cap);
        rx_busy = 1'b1;
        repeat (3 + $urandom_range(0, 3)) begin
            rx_data      = 8'($urandom);
            rx_parity_ok = 1'($urandom);
            step();
        end
        rx_data      = d;
        rx_parity_ok = ok;
        rx_busy      = 1'b0;
        repeat (3) step();
        if (pop_cap) begin
            out_ready = 1'b1;
            if (q.size() != 0) check("pop_cap_head", 32'(out_data), 32'(q[0]));
        end
        if (clr_cap) clear_stats = 1'b1;
        step();
        out_ready   = 1'b0;
        clear_stats = 1'b0;
        if (pop_cap && q.size() != 0) void'(q.pop_front());
        if (ok) begin
            if (q.size() < DEPTH) q.push_back(d);
            else                  m_ovr = 1'b1;
        end else if (m_err < 255) begin
            m_err++;
        end
        if (clr_cap) begin
            m_ovr = 1'b0;
            m_err = 0;
        end
        step();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic clear_pulse();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        m_ovr = 1'b0;
        m_err = 0;
    endtask

    initial begin
        logic [7:0] d;
        rst_n        = 1'b0;
        enable       = 1'b0;
        rx_busy      = 1'b0;
        rx_data      = 8'h00;
        rx_parity_ok = 1'b0;
        out_ready    = 1'b0;
        clear_stats  = 1'b0;

        // Reset state
        repeat (2) @(posedge sys_clk);
        #2;
        check("rst.valid",   32'(out_valid),      32'h0);
        check("rst.data",    32'(out_data),       32'h0);
        check("rst.count",   32'(fifo_count),     32'h0);
        check("rst.overrun", 32'(overrun),        32'h0);
        check("rst.errcnt",  32'(parity_err_cnt), 32'h0);
        #1 rst_n = 1'b1;
        step();
        enable = 1'b1;
        repeat (2) step();

        // Single good frame with latency check
        rx_busy = 1'b1;
        repeat (4) step();
        rx_data      = 8'hA5;
        rx_parity_ok = 1'b1;
        rx_busy      = 1'b0;
        repeat (3) step();
        check("single.early_valid", 32'(out_valid), 32'h0);
        step();
        check("single.valid", 32'(out_valid),  32'h1);
        check("single.data",  32'(out_data),   32'hA5);
        check("single.count", 32'(fifo_count), 32'h1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single.pop_valid", 32'(out_valid),  32'h0);
        check("single.pop_count", 32'(fifo_count), 32'h0);
        step();

        // Overrun: DEPTH+1 frames with consumer stalled
        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, 1'b0, 1'b0);
        check("ovr.count",   32'(fifo_count), 32'h4);
        check("ovr.overrun", 32'(overrun),    32'h1);
        check_model("ovr");
        for (int i = 1; i <= 4; i++) begin
            check("ovr.drain", 32'(out_data), 32'(i));
            pop_one();
        end
        check("ovr.empty", 32'(out_valid), 32'h0);
        clear_pulse();
        check("ovr.cleared", 32'(overrun), 32'h0);

        // Full FIFO with a pop on the capture edge
        for (int i = 0; i < 4; i++) frame(8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        frame(8'h77, 1'b1, 1'b1, 1'b0);
        check("fullpop.count",   32'(fifo_count), 32'h4);
        check("fullpop.overrun", 32'(overrun),    32'h0);
        for (int i = 1; i <= 3; i++) begin
            check("fullpop.drain", 32'(out_data), 32'(8'h10 + i));
            pop_one();
        end
        check("fullpop.last", 32'(out_data), 32'h77);
        pop_one();
        check_model("fullpop");

        // Parity errors, saturation, clear priority
        repeat (3) frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        check("par.cnt3",  32'(parity_err_cnt), 32'h3);
        check("par.empty", 32'(fifo_count),     32'h0);
        clear_pulse();
        repeat (260) frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        check("par.sat", 32'(parity_err_cnt), 32'hFF);
        frame(8'h00, 1'b0, 1'b0, 1'b1);
        check("par.clr_prio", 32'(parity_err_cnt), 32'h0);
        frame(8'h00, 1'b0, 1'b0, 1'b0);
        check("par.after_clr", 32'(parity_err_cnt), 32'h1);
        check_model("par");

        // Enable raised mid-frame: that frame is ignored
        enable = 1'b0;
        step();
        rx_busy = 1'b1;
        repeat (2) step();
        enable = 1'b1;
        repeat (3) step();
        rx_data      = 8'h3C;
        rx_parity_ok = 1'b1;
        rx_busy      = 1'b0;
        repeat (6) step();
        check("en.ignored", 32'(fifo_count), 32'h0);
        frame(8'h3D, 1'b1, 1'b0, 1'b0);
        check("en.next_count", 32'(fifo_count), 32'h1);
        check("en.next_data",  32'(out_data),   32'h3D);

        // Enable dropped during RECV: abandoned, FIFO retained and drainable while off
        rx_busy = 1'b1;
        repeat (5) step();
        enable = 1'b0;
        step();
        rx_data      = 8'h5A;
        rx_parity_ok = 1'b1;
        rx_busy      = 1'b0;
        repeat (6) step();
        check("en.abandon_count", 32'(fifo_count), 32'h1);
        check("en.retained",      32'(out_data),   32'h3D);
        check_model("en.off");
        pop_one();
        check("en.drained_off", 32'(fifo_count), 32'h0);
        enable = 1'b1;
        repeat (2) step();

        // Pointer wrap: 10 push/pop pairs
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            frame(d, 1'b1, 1'b0, 1'b0);
            check("wrap.data", 32'(out_data), 32'(d));
            pop_one();
            check("wrap.count", 32'(fifo_count), 32'h0);
        end

        // out_ready while empty does nothing
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("empty_ready.count", 32'(fifo_count), 32'h0);
        check("empty_ready.valid", 32'(out_valid),  32'h0);

        // Randomized frames against the model
        for (int i = 0; i < 60; i++) begin
            frame(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));
            check_model("rand.frame");
            repeat ($urandom_range(0, 2)) begin
                if (q.size() != 0) check("rand.pop_head", 32'(out_data), 32'(q[0]));
                pop_one();
            end
            check_model("rand.pop");
        end

        // Asynchronous reset with entries stored
        while (q.size() != 0) pop_one();
        frame(8'hE1, 1'b1, 1'b0, 1'b0);
        frame(8'hE2, 1'b1, 1'b0, 1'b0);
        check("rst2.pre_count", 32'(fifo_count), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_ovr = 1'b0;
        m_err = 0;
        check("rst2.valid",   32'(out_valid),      32'h0);
        check("rst2.data",    32'(out_data),       32'h0);
        check("rst2.count",   32'(fifo_count),     32'h0);
        check("rst2.overrun", 32'(overrun),        32'h0);
        check("rst2.errcnt",  32'(parity_err_cnt), 32'h0);
        #2 rst_n = 1'b1;
        repeat (2) step();
        frame(8'hC3, 1'b1, 1'b0, 1'b0);
        check_model("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_ctrl.md
# rx_ctrl

Receive-side controller that sits between the `receiver` block and the system bus logic, in the `sys_clk` domain. It synchronises the receiver's `busy` flag and detects the end of each frame. At frame end it captures the 8-bit byte and its parity result. Good bytes go into a small FIFO behind a valid/ready handshake; bad-parity bytes are dropped and counted, and dropped good bytes raise a sticky overrun flag.

## Interface
Parameters:
- `DEPTH`, default 4: number of FIFO entries; power of two, 2 to 16.

Ports:
- `sys_clk`  in  1: system clock; the only clock in the block.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: 1 = accept frames; 0 = block idles and does not capture.
- `rx_busy`  in  1: `busy` from the receiver; asynchronous to this block.
- `rx_data`  in  8: `parallel_data_out` from the receiver; stable while `rx_busy` = 0.
- `rx_parity_ok`  in  1: `data_valid` from the receiver; 1 = parity good.
- `out_data`  out  8: byte at the FIFO head.
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `fifo_count`  out  $clog2(DEPTH)+1: number of FIFO entries.
- `overrun`  out  1: sticky; a good byte was dropped because the FIFO was full.
- `parity_err_cnt`  out  8: count of dropped bad-parity frames; saturates at 255.
- `clear_stats`  in  1: one-cycle pulse; clears `overrun` and `parity_err_cnt`.

## Operation
- **Synchroniser:** `rx_busy` passes through two flops (`busy_s`); the FSM uses only `busy_s`.
- **FSM states:** OFF, IDLE, RECV, CAPTURE. Reset state is OFF.
  - OFF -> IDLE when `enable`=1 and `busy_s`=0. A frame already in progress when the block is enabled is ignored.
  - IDLE -> RECV when `busy_s`=1.
  - RECV -> CAPTURE when `busy_s`=0.
  - CAPTURE -> IDLE unconditionally, after one cycle.
  - `enable`=0 in any state -> OFF next cycle. A frame in RECV is abandoned with no capture and no count.
- **CAPTURE cycle:** samples `rx_data` and `rx_parity_ok`.
  - Parity bad: byte dropped; `parity_err_cnt` += 1, saturating at 255.
  - Parity good, FIFO has room: byte pushed.
  - Parity good, FIFO full with no pop this cycle: byte dropped; `overrun` <= 1.
  - Parity good, FIFO full with a pop this same cycle: push accepted; no overrun.
- **FIFO:** circular buffer with read/write pointers that wrap modulo `DEPTH`.
  - `out_data` shows the head entry with no read latency.
  - Pop happens when `out_valid`=1 and `out_ready`=1.
  - `out_ready` while empty has no effect.
  - `fifo_count` changes by +1 on push only, -1 on pop only, 0 on both.
- **clear_stats:** has priority over a same-cycle parity-error increment or overrun set; that event is lost. FIFO contents are not affected.
- `enable` does not flush the FIFO; the consumer can drain it while the block is OFF.

## Timing
- **Reset values:** state OFF, `busy_s`=0, both pointers 0, `out_valid`=0, `out_data`=8'h00, `fifo_count`=0, `overrun`=0, `parity_err_cnt`=0.
- **Reset mid-operation:** immediately returns everything to the reset values; FIFO contents are lost.
- **Capture latency:** `rx_busy` is first sampled low at edge k.
  - `busy_s`=0 after edge k+1.
  - FSM enters CAPTURE at edge k+2.
  - Push or count happens at edge k+3.
  - `out_valid` rises after edge k+3 if the FIFO was empty.
- **Pop:** takes effect at the sampling edge. The next entry, or `out_valid`=0, appears after that edge.
- **Back-to-back frames:** the receiver's idle gap between frames (at least one baud period) exceeds 3 `sys_clk` cycles. No frame is missed when `sys_clk` >= 4x the baud clock.

## Test plan
- **Single good frame:** reset, `enable`=1, `rx_busy` pulse, then `rx_data`=8'hA5 with `rx_parity_ok`=1 -> `out_valid` rises 3 cycles after `rx_busy` falls; `out_data`=8'hA5; `fifo_count`=1; pulse `out_ready` -> `out_valid`=0, `fifo_count`=0.
- **Overrun:** `out_ready`=0, send DEPTH+1 good frames 8'h01..8'h05 (DEPTH=4) -> `fifo_count`=4, `overrun`=1; drain gives 01, 02, 03, 04 in order; `clear_stats` -> `overrun`=0.
- **Full with simultaneous pop:** FIFO full, hold `out_ready`=1 during a CAPTURE cycle with 8'h77 -> no overrun; `fifo_count` stays 4; 8'h77 is the last entry drained.
- **Parity errors:** 3 frames with `rx_parity_ok`=0 -> `parity_err_cnt`=3, FIFO stays empty; 260 bad frames -> counter holds 255; `clear_stats` on the same cycle as a bad capture -> counter reads 0.
- **Enable gating:** raise `enable` while `rx_busy`=1 -> that frame is not captured, the next one is; drop `enable` during RECV -> no capture, FIFO contents retained and drainable.
- **Pointer wrap and reset:** 10 push/pop pairs with DEPTH=4 -> data order preserved across pointer wrap; assert `rst_n`=0 with 2 entries stored -> all outputs return to reset values immediately.
